// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// Grants are held for up to MAX_BURST transfers while the other side waits.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ready_a,
  input  logic             valid_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [4:0] LP_BURST = 5'(MAX_BURST);

  state_t           r_state;
  logic             r_ptr;
  logic [3:0]       r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;
  logic             r_busy;

  logic             w_space;
  logic             w_ready_a;
  logic             w_ready_b;
  logic             w_xfer;
  logic [4:0]       w_cnt_next;
  logic             w_burst_end;
  logic             w_own_valid;
  logic             w_oth_valid;
  logic             w_leaving_a;

  assign w_space     = !r_out_valid || out_ready;
  assign w_ready_a   = !reset && (r_state == GNT_A) && valid_a && w_space;
  assign w_ready_b   = !reset && (r_state == GNT_B) && valid_b && w_space;
  assign w_xfer      = w_ready_a || w_ready_b;
  assign w_cnt_next  = {1'b0, r_cnt} + {4'd0, w_xfer};
  assign w_burst_end = w_xfer && (w_cnt_next == LP_BURST);
  assign w_leaving_a = (r_state == GNT_A);

  // Requester valids seen from the granted side's point of view.
  always_comb begin
    w_own_valid = 1'b0;
    w_oth_valid = 1'b0;
    case (r_state)
      GNT_A: begin
        w_own_valid = valid_a;
        w_oth_valid = valid_b;
      end
      GNT_B: begin
        w_own_valid = valid_b;
        w_oth_valid = valid_a;
      end
      default: begin
        w_own_valid = 1'b0;
        w_oth_valid = 1'b0;
      end
    endcase
  end

  // Grant FSM with pointer, burst counter and registered sel/busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_cnt   <= 4'd0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 4'd0;
          if (valid_a && (!valid_b || !r_ptr)) begin
            r_state <= GNT_A;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
          end else if (valid_b) begin
            r_state <= GNT_B;
            r_sel   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        GNT_A, GNT_B: begin
          if (w_oth_valid && (!w_own_valid || w_burst_end)) begin
            r_state <= w_leaving_a ? GNT_B : GNT_A;
            r_sel   <= w_leaving_a;
            r_ptr   <= w_leaving_a;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
          end else if (!w_own_valid && !w_oth_valid) begin
            r_state <= IDLE;
            r_ptr   <= w_leaving_a;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
          end else if (w_burst_end) begin
            // Burst limit hit with no competitor: restart the count, keep the grant.
            r_cnt <= 4'd0;
          end else begin
            r_cnt <= w_cnt_next[3:0];
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register; a load wins over a simultaneous consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_ready_a) begin
      r_out_valid <= 1'b1;
      r_out_data  <= data_a;
    end else if (w_ready_b) begin
      r_out_valid <= 1'b1;
      r_out_data  <= data_b;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign ready_a   = w_ready_a;
  assign ready_b   = w_ready_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_mux2_rr_arbiter;

  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_a, valid_b, out_ready;
  logic [WIDTH-1:0] data_a, data_b;
  logic             ready_a, ready_b, out_valid, sel, busy;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .valid_a(valid_a), .data_a(data_a), .ready_a(ready_a),
    .valid_b(valid_b), .data_b(data_b), .ready_b(ready_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    valid_a = 1'b0; valid_b = 1'b0; out_ready = 1'b0;
    data_a = 16'h0000; data_b = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_a = 1'b1; valid_b = 1'b1; out_ready = 1'b1;
    data_a = 16'h1357; data_b = 16'h2468;
    tick(); settle();
    n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
    n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b: got %b want 0", ready_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_basic_a();
    do_reset();
    valid_a = 1'b1; data_a = 16'hFFFF; out_ready = 1'b1;
    settle();
    n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL basic_a_idle_ready: got %b want 0", ready_a); end
    tick(); settle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_a_busy: got %b want 1", busy); end
    n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL basic_a_sel: got %b want 0", sel); end
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL basic_a_ready: got %b want 1", ready_a); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_a_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 16'hFFFF) begin n_fail++; $display("FAIL basic_a_out_data: got %h want ffff", out_data); end
    valid_a = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_a_idle_busy: got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_a_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_basic_b();
    do_reset();
    valid_b = 1'b1; data_b = 16'hDCBA; out_ready = 1'b1;
    tick(); settle();
    n_checks++; if (sel !== 1'b1) begin n_fail++; $display("FAIL basic_b_sel: got %b want 1", sel); end
    n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL basic_b_ready: got %b want 1", ready_b); end
    tick();
    n_checks++; if (out_data !== 16'hDCBA) begin n_fail++; $display("FAIL basic_b_out_data: got %h want dcba", out_data); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_b_out_valid: got %b want 1", out_valid); end
    valid_b = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_b_idle_busy: got %b want 0", busy); end
    n_checks++; if (sel !== 1'b1) begin n_fail++; $display("FAIL basic_b_sel_hold: got %b want 1", sel); end
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] exp;
    do_reset();
    valid_a = 1'b1; data_a = 16'hABCD; valid_b = 1'b1; data_b = 16'h5985; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = (((i / MAX_BURST) % 2) == 0) ? 16'hABCD : 16'h5985;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++;
        $display("FAIL contention_word%0d: got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, exp);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    valid_a = 1'b1; data_a = 16'h1111; out_ready = 1'b0;
    tick(); settle();
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b want 1", ready_a); end
    tick();
    data_a = 16'h2222;
    settle();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ready_a !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h1111) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b data=%h want ready=0 valid=1 data=1111", k, ready_a, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", ready_a); end
    tick();
    n_checks++; if (out_data !== 16'h2222) begin n_fail++; $display("FAIL bp_resume_data0: got %h want 2222", out_data); end
    data_a = 16'h3333;
    settle();
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready: got %b want 1", ready_a); end
    tick();
    n_checks++; if (out_data !== 16'h3333 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_data1: got valid=%b data=%h want valid=1 data=3333", out_valid, out_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_withdrawal();
    do_reset();
    valid_a = 1'b1; data_a = 16'h0A0A; valid_b = 1'b1; data_b = 16'h0B0B; out_ready = 1'b1;
    tick(); settle();
    n_checks++; if (ready_a !== 1'b1 || ready_b !== 1'b0) begin n_fail++; $display("FAIL wd_first_grant: got a=%b b=%b want a=1 b=0", ready_a, ready_b); end
    tick();
    valid_a = 1'b0;
    settle();
    n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin n_fail++; $display("FAIL wd_drop_cycle: got a=%b b=%b want a=0 b=0", ready_a, ready_b); end
    tick();
    valid_a = 1'b1;
    settle();
    n_checks++; if (sel !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_switch: got sel=%b busy=%b want sel=1 busy=1", sel, busy); end
    // A full burst for B shows its count started from zero.
    for (int k = 0; k < MAX_BURST; k++) begin
      n_checks++;
      if (ready_b !== 1'b1 || ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_b_burst%0d: got a=%b b=%b want a=0 b=1", k, ready_a, ready_b);
      end
      tick();
    end
    n_checks++; if (ready_a !== 1'b1 || ready_b !== 1'b0) begin n_fail++; $display("FAIL wd_back_to_a: got a=%b b=%b want a=1 b=0", ready_a, ready_b); end
    tick();
    valid_a = 1'b0; valid_b = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || sel !== 1'b0) begin n_fail++; $display("FAIL wd_to_idle: got busy=%b sel=%b want busy=0 sel=0", busy, sel); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    valid_a = 1'b1; data_a = 16'h1234; out_ready = 1'b1;
    tick();
    valid_a = 1'b0; valid_b = 1'b1; data_b = 16'h5678;
    tick(); settle();
    n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL rmb_first_b: got %b want 1", ready_b); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_pending: got %b want 1", out_valid); end
    reset = 1'b1;
    settle();
    n_checks++; if (ready_b !== 1'b0 || ready_a !== 1'b0) begin n_fail++; $display("FAIL rmb_ready_in_reset: got a=%b b=%b want 0 0", ready_a, ready_b); end
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmb_after_reset: got busy=%b valid=%b sel=%b data=%h want 0 0 0 0000", busy, out_valid, sel, out_data);
    end
    reset = 1'b0; valid_a = 1'b1;
    tick(); settle();
    n_checks++; if (sel !== 1'b0 || ready_a !== 1'b1) begin n_fail++; $display("FAIL rmb_ptr_a: got sel=%b ready_a=%b want sel=0 ready_a=1", sel, ready_a); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int gnt, ptr, cnt, nc;
    bit ov, sel_m, sp, ra, rb, acc_a, acc_b, own, oth;
    logic [WIDTH-1:0] od;
    do_reset();
    gnt = 0; ptr = 0; cnt = 0; ov = 1'b0; sel_m = 1'b0; od = 16'h0000;
    acc_a = 1'b1; acc_b = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters hold a pending word, occasionally withdrawing it.
      if (valid_a && !acc_a) begin
        if ($urandom_range(15, 0) == 0) valid_a = 1'b0;
      end else begin
        valid_a = ($urandom_range(3, 0) != 0);
        data_a  = 16'($urandom);
      end
      if (valid_b && !acc_b) begin
        if ($urandom_range(15, 0) == 0) valid_b = 1'b0;
      end else begin
        valid_b = ($urandom_range(3, 0) != 0);
        data_b  = 16'($urandom);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      reset     = ($urandom_range(199, 0) == 0);
      settle();

      sp = !ov || out_ready;
      ra = !reset && (gnt == 1) && valid_a && sp;
      rb = !reset && (gnt == 2) && valid_b && sp;

      n_checks++; if (ready_a !== ra) begin n_fail++; $display("FAIL rand_ready_a cyc%0d: got %b want %b", cyc, ready_a, ra); end
      n_checks++; if (ready_b !== rb) begin n_fail++; $display("FAIL rand_ready_b cyc%0d: got %b want %b", cyc, ready_b, rb); end
      n_checks++; if (out_valid !== ov) begin n_fail++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", cyc, out_valid, ov); end
      n_checks++; if (out_data !== od) begin n_fail++; $display("FAIL rand_out_data cyc%0d: got %h want %h", cyc, out_data, od); end
      n_checks++; if (sel !== sel_m) begin n_fail++; $display("FAIL rand_sel cyc%0d: got %b want %b", cyc, sel, sel_m); end
      n_checks++; if (busy !== (gnt != 0)) begin n_fail++; $display("FAIL rand_busy cyc%0d: got %b want %b", cyc, busy, (gnt != 0)); end

      if (reset) begin
        gnt = 0; ptr = 0; cnt = 0; ov = 1'b0; od = 16'h0000; sel_m = 1'b0;
      end else begin
        if (ra) begin od = data_a; ov = 1'b1; end
        else if (rb) begin od = data_b; ov = 1'b1; end
        else if (out_ready) ov = 1'b0;

        if (gnt == 0) begin
          if (valid_a && valid_b) gnt = ptr + 1;
          else if (valid_a) gnt = 1;
          else if (valid_b) gnt = 2;
        end else begin
          own = (gnt == 1) ? valid_a : valid_b;
          oth = (gnt == 1) ? valid_b : valid_a;
          nc  = cnt + ((ra || rb) ? 1 : 0);
          if (oth && (!own || nc == MAX_BURST)) begin
            ptr = (gnt == 1) ? 1 : 0; gnt = 3 - gnt; cnt = 0;
          end else if (!own && !oth) begin
            ptr = (gnt == 1) ? 1 : 0; gnt = 0; cnt = 0;
          end else begin
            cnt = (nc == MAX_BURST) ? 0 : nc;
          end
        end
        if (gnt == 1) sel_m = 1'b0;
        else if (gnt == 2) sel_m = 1'b1;
      end
      acc_a = ra;
      acc_b = rb;
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic_a();
    test_basic_b();
    test_contention();
    test_backpressure();
    test_withdrawal();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of each requester and of the output port.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive transfers granted to one requester while the other is waiting; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port valid_a, input, 1 bit: requester A presents data.
REQ-006 The block SHALL have port data_a, input, WIDTH bits: requester A data, mux input selected when sel=0.
REQ-007 The block SHALL have port ready_a, output, 1 bit: requester A transfer accepted this cycle.
REQ-008 The block SHALL have port valid_b, input, 1 bit: requester B presents data.
REQ-009 The block SHALL have port data_b, input, WIDTH bits: requester B data, mux input selected when sel=1.
REQ-010 The block SHALL have port ready_b, output, 1 bit: requester B transfer accepted this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: registered mux output.
REQ-014 The block SHALL have port sel, output, 1 bit: current mux select, 0=A, 1=B.
REQ-015 The block SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, GNT_A and GNT_B, plus a 1-bit priority pointer and a 4-bit burst counter.
REQ-017 The output stage SHALL be a one-entry register: space = !out_valid || out_ready.
REQ-018 ready_a SHALL be combinational and equal (state==GNT_A) && valid_a && space; ready_b SHALL be defined the same way for GNT_B.
REQ-019 On ready_x, out_data SHALL load data_x and out_valid SHALL be set at the next edge, giving a latency of exactly 1 cycle.
REQ-020 When out_valid && out_ready occur with no new load, out_valid SHALL clear; a simultaneous load and consume SHALL keep out_valid=1 and carry the new data.
REQ-021 While out_valid && !out_ready, out_data SHALL be held stable.
REQ-022 From IDLE, the FSM SHALL move next cycle to GNT_A if only valid_a, to GNT_B if only valid_b, and to the side named by the pointer if both are asserted; it SHALL stay in IDLE if neither is asserted.
REQ-023 From GNT_A, the FSM SHALL go to GNT_B if valid_b && (!valid_a || burst count reaches MAX_BURST on this cycle's transfer); it SHALL go to IDLE if !valid_a && !valid_b; otherwise it SHALL stay in GNT_A.
REQ-024 GNT_B SHALL be symmetric to GNT_A.
REQ-025 The burst counter SHALL increment on each ready_x of the granted side and clear on any state change.
REQ-026 If the count reaches MAX_BURST while the other side is idle, the counter SHALL clear and the grant SHALL be kept.
REQ-027 On leaving GNT_x, the pointer SHALL point to the other side.
REQ-028 sel SHALL equal 0 in GNT_A and 1 in GNT_B, and SHALL hold its last value in IDLE.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 A grant change SHALL take effect the cycle after the decision, so no ready is asserted for the old side in the cycle the new state is entered.
REQ-031 Requesters SHALL hold valid_x and data_x stable until ready_x; a valid drop without ready SHALL be treated as a withdrawal.

Reset
REQ-032 While reset=1 at an edge, the block SHALL set state=IDLE, pointer=A, burst counter=0, out_valid=0, out_data=0 and sel=0.
REQ-033 Reset SHALL override all other inputs, including mid-burst and while out_valid=1; the pending word SHALL be discarded.
REQ-034 While reset=1, ready_a and ready_b SHALL be 0.

Verification
REQ-035 Basic A: valid_a=1, data_a=16'hFFFF, out_ready=1 from IDLE -> GNT_A at cycle 1, ready_a at cycle 1, out_data=FFFF with out_valid=1 at cycle 2, sel=0.
REQ-036 Basic B: valid_b=1, data_b=16'hDCBA -> GNT_B, sel=1, out_data=DCBA one cycle after ready_b.
REQ-037 Contention: both valid constantly, data_a=ABCD, data_b=5985, out_ready=1, MAX_BURST=4 -> output sequence 4×ABCD, then 4×5985, alternating; first grant goes to A after reset.
REQ-038 Backpressure: out_ready=0 with valid_a=1 -> one word loaded, ready_a=0 thereafter, out_data stable; releasing out_ready -> one transfer per cycle resumes.
REQ-039 Withdrawal/switch: in GNT_A, valid_a drops while valid_b=1 -> GNT_B next cycle with counter=0; both drop -> IDLE, busy=0, sel holds.
REQ-040 Reset mid-burst: assert reset during the 2nd transfer of a GNT_B burst with out_valid=1 -> next cycle IDLE, out_valid=0, sel=0, pointer=A.
